// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Feeds the dual-MAC datapath. Collects a valid/ready byte stream into four
//   operand registers (A1, B1, A2, B2), pulses the MAC clock enable once per
//   operand set, flushes the MAC pipeline with zero operands, waits for the
//   result register capture and then strobes the PISO parallel load.
//   One start produces one dot product of VEC_LEN element pairs per MAC.
//
// Ports
//   clk        in   clock, rising edge
//   aclr       in   asynchronous reset, active high
//   start      in   begin a new vector (looked at only while idle)
//   s_data     in   [7:0] operand byte stream
//   s_valid    in   s_data valid
//   s_ready    out  byte accepted this cycle when s_valid is high
//   op_a1      out  [7:0] MAC1 operand c
//   op_b1      out  [7:0] MAC1 operand d
//   op_a2      out  [7:0] MAC2 operand c
//   op_b2      out  [7:0] MAC2 operand d
//   mac_clken  out  MAC clock enable
//   mac_clr    out  MAC accumulator clear, one-cycle pulse
//   res_ld     out  PISO parallel load, one-cycle pulse
//   busy       out  high whenever not idle
//   done       out  one-cycle pulse, coincident with res_ld
//
// States
//   S_IDLE  | waiting for start
//   S_CLEAR | clear MAC accumulators, reset byte/element counters
//   S_LOAD  | accept four bytes into op_a1, op_b1, op_a2, op_b2
//   S_ISSUE | one MAC clock enable with the loaded operand set
//   S_DRAIN | PIPE_DEPTH clock enables with zero operands
//   S_WAIT  | RES_DLY idle cycles for the result register capture
//   S_OUT   | res_ld / done pulse

module mac_operand_sequencer #(
    parameter int VEC_LEN    = 8,
    parameter int PIPE_DEPTH = 2,
    parameter int RES_DLY    = 1
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] op_a1,
    output logic [7:0] op_b1,
    output logic [7:0] op_a2,
    output logic [7:0] op_b2,
    output logic       mac_clken,
    output logic       mac_clr,
    output logic       res_ld,
    output logic       busy,
    output logic       done
);

    localparam int EW   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int DMAX = (PIPE_DEPTH > RES_DLY) ? PIPE_DEPTH : RES_DLY;
    localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

    localparam logic [EW-1:0] ELEM_LAST = EW'(VEC_LEN - 1);
    localparam logic [DW-1:0] DRAIN_LD  = DW'(PIPE_DEPTH - 1);
    localparam logic [DW-1:0] WAIT_LD   = DW'(RES_DLY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_WAIT,
        S_OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    byte_idx;
    logic [EW-1:0] elem_cnt;
    logic [DW-1:0] dly_cnt;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_LOAD;
            S_LOAD:  if (s_valid && byte_idx == 2'd3) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (elem_cnt == ELEM_LAST) ? S_DRAIN : S_LOAD;
            S_DRAIN: if (dly_cnt == '0) state_nxt = S_WAIT;
            S_WAIT:  if (dly_cnt == '0) state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, element counter and the shared drain/wait
    // down-counter (loaded on entry, state advances on terminal count 0).
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            op_a1    <= '0;
            op_b1    <= '0;
            op_a2    <= '0;
            op_b2    <= '0;
            byte_idx <= '0;
            elem_cnt <= '0;
            dly_cnt  <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    byte_idx <= '0;
                    elem_cnt <= '0;
                end
                S_LOAD: begin
                    if (s_valid) begin
                        case (byte_idx)
                            2'd0: op_a1 <= s_data;
                            2'd1: op_b1 <= s_data;
                            2'd2: op_a2 <= s_data;
                            2'd3: op_b2 <= s_data;
                            default: ;
                        endcase
                        // 2-bit index wraps 3 -> 0, ready for the next set
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_ISSUE: begin
                    if (elem_cnt == ELEM_LAST) begin
                        // flush the MAC pipeline with zero operands
                        op_a1   <= '0;
                        op_b1   <= '0;
                        op_a2   <= '0;
                        op_b2   <= '0;
                        dly_cnt <= DRAIN_LD;
                    end else begin
                        elem_cnt <= elem_cnt + EW'(1);
                    end
                end
                S_DRAIN: begin
                    if (dly_cnt == '0) dly_cnt <= WAIT_LD;
                    else               dly_cnt <= dly_cnt - DW'(1);
                end
                S_WAIT: begin
                    if (dly_cnt != '0) dly_cnt <= dly_cnt - DW'(1);
                end
                default: ;
            endcase
        end
    end

    assign s_ready   = (state == S_LOAD);
    assign mac_clken = (state == S_ISSUE) || (state == S_DRAIN);
    assign mac_clr   = (state == S_CLEAR);
    assign res_ld    = (state == S_OUT);
    assign done      = (state == S_OUT);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: three instances (VEC_LEN 1, 2, 8) share
// the byte stream; one is exercised at a time. Stimulus pushes the expected
// operand sets and dot-product results; the monitor pops them as the DUT
// raises mac_clken / res_ld and checks them against a downstream MAC model.

module tb_mac_operand_sequencer;

    localparam int ND = 3;
    localparam int PD = 2;
    localparam int RD = 1;

    function automatic int vl_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    typedef logic [7:0] bytes_t[$];

    logic          clk = 1'b0;
    logic          aclr = 1'b1;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic [ND-1:0] start_v = '0;
    logic [ND-1:0] s_ready_v, mac_clken_v, mac_clr_v, res_ld_v, busy_v, done_v;
    logic [7:0]    a1_v[ND];
    logic [7:0]    b1_v[ND];
    logic [7:0]    a2_v[ND];
    logic [7:0]    b2_v[ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mac_operand_sequencer #(
            .VEC_LEN(vl_of(g)), .PIPE_DEPTH(PD), .RES_DLY(RD)
        ) u_dut (
            .clk(clk), .aclr(aclr), .start(start_v[g]),
            .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_v[g]),
            .op_a1(a1_v[g]), .op_b1(b1_v[g]), .op_a2(a2_v[g]), .op_b2(b2_v[g]),
            .mac_clken(mac_clken_v[g]), .mac_clr(mac_clr_v[g]),
            .res_ld(res_ld_v[g]), .busy(busy_v[g]), .done(done_v[g])
        );
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t_start = 0;
    int exp_lat = -1;
    bit held_chk = 1'b0;

    logic [31:0] exp_ops[$];
    logic [33:0] exp_res[$];
    int acc1[ND];
    int acc2[ND];
    int res_cnt[ND];
    int exp_cnt[ND];
    int clr_due[ND];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: downstream MAC model plus scoreboard pops.
    initial begin
        for (int d = 0; d < ND; d++) begin
            acc1[d] = 0; acc2[d] = 0; res_cnt[d] = 0; clr_due[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (clr_due[d] > 0) begin
                    clr_due[d]--;
                    if (clr_due[d] == 0) check("held_restart_clr", 64'(mac_clr_v[d]), 64'd1);
                end
                if (mac_clr_v[d]) begin
                    acc1[d] = 0;
                    acc2[d] = 0;
                end
                if (s_ready_v[d]) check("clken_in_load", 64'(mac_clken_v[d]), 64'd0);
                if (mac_clken_v[d]) begin
                    if (exp_ops.size() == 0) begin
                        check("unexpected_clken", 64'd1, 64'd0);
                    end else begin
                        logic [31:0] e;
                        e = exp_ops.pop_front();
                        check("operands", 64'({a1_v[d], b1_v[d], a2_v[d], b2_v[d]}), 64'(e));
                    end
                    acc1[d] = (acc1[d] + int'(a1_v[d]) * int'(b1_v[d])) % 131072;
                    acc2[d] = (acc2[d] + int'(a2_v[d]) * int'(b2_v[d])) % 131072;
                end
                if (res_ld_v[d] || done_v[d]) check("done_eq_res_ld", 64'(done_v[d]), 64'(res_ld_v[d]));
                if (res_ld_v[d]) begin
                    res_cnt[d]++;
                    if (exp_res.size() == 0) begin
                        check("unexpected_res_ld", 64'd1, 64'd0);
                    end else begin
                        logic [33:0] r;
                        r = exp_res.pop_front();
                        check("mac_out1", 64'(acc1[d]), 64'(r[33:17]));
                        check("mac_out2", 64'(acc2[d]), 64'(r[16:0]));
                    end
                    if (exp_lat >= 0) begin
                        check("res_ld_latency", 64'(cyc + 1 - t_start), 64'(exp_lat));
                        exp_lat = -1;
                    end
                    if (held_chk) begin
                        clr_due[d] = 2;
                        held_chk = 1'b0;
                    end
                end
            end
        end
    end

    // Expected behaviour of one vector: VEC_LEN operand sets, then PD zero
    // sets, then the two dot products modulo 2^17.
    task automatic push_vec(input int d, input bytes_t b);
        int s1 = 0;
        int s2 = 0;
        for (int e = 0; e < vl_of(d); e++) begin
            exp_ops.push_back({b[4*e], b[4*e+1], b[4*e+2], b[4*e+3]});
            s1 = (s1 + int'(b[4*e]) * int'(b[4*e+1])) % 131072;
            s2 = (s2 + int'(b[4*e+2]) * int'(b[4*e+3])) % 131072;
        end
        for (int p = 0; p < PD; p++) exp_ops.push_back(32'd0);
        exp_res.push_back({17'(s1), 17'(s2)});
        exp_cnt[d]++;
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk); #1;
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        t_start = cyc;
        start_v[d] = 1'b0;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input int gap);
        bit got = 1'b0;
        repeat (gap) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_data = b;
        s_valid = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (s_ready_v[d]) got = 1'b1;
        end
        if (!got) check("s_ready_timeout", 64'd0, 64'd1);
        else begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    // gmode: 0 back-to-back, 1 one idle cycle before each byte, 2 random gaps
    task automatic send_vec(input int d, input bytes_t b, input int gmode, input bit poke);
        for (int i = 0; i < b.size(); i++) begin
            int gap;
            gap = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
            if (poke && i == 1) start_v[d] = 1'b1;
            send_byte(d, b[i], gap);
            if (poke && i == 1) start_v[d] = 1'b0;
        end
        if (poke) begin
            // start high across ISSUE and the first DRAIN cycle
            start_v[d] = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            start_v[d] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d);
        bit idle = 1'b0;
        for (int n = 0; n < 100 && !idle; n++) begin
            @(negedge clk);
            if (!busy_v[d]) idle = 1'b1;
        end
        check("return_to_idle", 64'(idle), 64'd1);
    endtask

    task automatic run_vec(input int d, input bytes_t b, input int gmode, input bit lat, input bit poke);
        push_vec(d, b);
        pulse_start(d);
        if (lat) exp_lat = 2 + 5 * vl_of(d) + PD + RD;
        send_vec(d, b, gmode, poke);
        wait_idle(d);
    endtask

    function automatic bytes_t rand_bytes(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    initial begin
        bytes_t v3, vff, v1, v2;
        for (int d = 0; d < ND; d++) exp_cnt[d] = 0;
        v3  = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd2, 8'd2, 8'd1, 8'd1};
        vff = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};

        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < ND; d++) begin
            check("rst_busy", 64'(busy_v[d]), 64'd0);
            check("rst_s_ready", 64'(s_ready_v[d]), 64'd0);
            check("rst_strobes", 64'({mac_clken_v[d], mac_clr_v[d], res_ld_v[d], done_v[d]}), 64'd0);
            check("rst_ops", 64'({a1_v[d], b1_v[d], a2_v[d], b2_v[d]}), 64'd0);
        end
        @(posedge clk); #1;
        aclr = 1'b0;
        repeat (2) @(posedge clk);

        // single element pair, latency from start edge
        run_vec(0, '{8'd3, 8'd4, 8'd5, 8'd6}, 0, 1'b1, 1'b0);
        // two element pairs, back-to-back then throttled
        run_vec(1, v3, 0, 1'b1, 1'b0);
        run_vec(1, v3, 1, 1'b0, 1'b0);
        // start pokes while busy are ignored
        run_vec(1, v3, 0, 1'b0, 1'b1);
        // saturated operands, twice to prove the accumulator clear
        run_vec(1, vff, 0, 1'b0, 1'b0);
        run_vec(1, vff, 2, 1'b0, 1'b0);

        // start held: back-to-back vectors
        v1 = rand_bytes(8);
        v2 = rand_bytes(8);
        push_vec(1, v1);
        held_chk = 1'b1;
        @(posedge clk); #1;
        start_v[1] = 1'b1;
        send_vec(1, v1, 0, 1'b0);
        push_vec(1, v2);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(negedge clk);
                if (mac_clr_v[1]) seen = 1'b1;
            end
            check("held_retrigger", 64'(seen), 64'd1);
        end
        start_v[1] = 1'b0;
        send_vec(1, v2, 0, 1'b0);
        wait_idle(1);

        // asynchronous reset mid-LOAD with two bytes taken
        pulse_start(2);
        send_byte(2, 8'd3, 0);
        send_byte(2, 8'd4, 0);
        #2;
        aclr = 1'b1;
        #1;
        check("aclr_busy", 64'(busy_v[2]), 64'd0);
        check("aclr_s_ready", 64'(s_ready_v[2]), 64'd0);
        check("aclr_ops", 64'({a1_v[2], b1_v[2], a2_v[2], b2_v[2]}), 64'd0);
        check("aclr_strobes", 64'({mac_clken_v[2], mac_clr_v[2], res_ld_v[2], done_v[2]}), 64'd0);
        @(posedge clk); #1;
        aclr = 1'b0;
        repeat (40) @(posedge clk);

        // randomized vectors on every instance
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < 3; k++) begin
                run_vec(d, rand_bytes(4 * vl_of(d)), 2, 1'b0, 1'b0);
            end
        end

        repeat (5) @(posedge clk);
        for (int d = 0; d < ND; d++) check("res_ld_count", 64'(res_cnt[d]), 64'(exp_cnt[d]));
        check("ops_queue_empty", 64'(exp_ops.size()), 64'd0);
        check("res_queue_empty", 64'(exp_res.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
